// File: rtl/instr_buf_pkg.sv
// Shared definitions for the instruction issue buffer.
//   - RV32I opcode constants used for classification
//   - instr_cat_e: one-hot category matching instr_category_bm
//   - entry_t: FIFO entry payload {instr, cat}
package instr_buf_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OPC_W   = 7;
  localparam int unsigned CAT_W   = 3;

  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;

  typedef enum logic [CAT_W-1:0] {
    CAT_NONE  = 3'b000,
    CAT_LOAD  = 3'b001,
    CAT_STORE = 3'b010,
    CAT_ARITH = 3'b100
  } instr_cat_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    instr_cat_e         cat;
  } entry_t;

endpackage

// File: rtl/instr_classifier.sv
// Opcode to one-hot category decoder (purely combinational).
// Ports:
//   opcode  in  7  instruction bits [6:0]
//   cat_c   out 3  one-hot category, CAT_NONE for unsupported opcodes
module instr_classifier
  import instr_buf_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output instr_cat_e       cat_c
);

  always_comb begin
    cat_c = CAT_NONE;
    case (opcode)
      OPC_LOAD:             cat_c = CAT_LOAD;
      OPC_STORE:            cat_c = CAT_STORE;
      OPC_OP, OPC_OP_IMM:   cat_c = CAT_ARITH;
      default:              cat_c = CAT_NONE;
    endcase
  end

endmodule

// File: rtl/instr_issue_buffer.sv
// Instruction issue buffer: classifies incoming RV32I words, drops words whose
// category is masked off (counting them), and queues the rest in a FIFO.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               synchronous FIFO clear (drop_cnt preserved)
//   cat_mask[2:0]       enabled categories {ARITH, STORE, LOAD}
//   in_valid/in_ready   input handshake, in_instr[31:0] payload
//   out_valid/out_ready output handshake, out_instr/out_cat head payload
//   count               occupancy, drop_cnt saturating filtered-word count
// Optional: `define INSTR_ISSUE_STATS_EN adds load_cnt/store_cnt/arith_cnt,
//   wrapping counts of stored words per category.
module instr_issue_buffer
  import instr_buf_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned DROP_CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [CAT_W-1:0]          cat_mask,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [INSTR_W-1:0]        in_instr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [INSTR_W-1:0]        out_instr,
  output logic [CAT_W-1:0]          out_cat,
  output logic [$clog2(DEPTH):0]    count,
  output logic [DROP_CNT_W-1:0]     drop_cnt
`ifdef INSTR_ISSUE_STATS_EN
  ,
  output logic [31:0]               load_cnt,
  output logic [31:0]               store_cnt,
  output logic [31:0]               arith_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  instr_cat_e       in_cat_c;
  entry_t           in_entry;
  entry_t           mem [DEPTH];
  entry_t           head, head_nx;
  logic [PTR_W-1:0] rd_ptr, rd_ptr_nx, wr_ptr, wr_ptr_nx;
  logic [CNT_W-1:0] count_nx;
  logic             accept, store, drop, pop;

  instr_classifier u_classifier (
    .opcode (in_instr[OPC_W-1:0]),
    .cat_c  (in_cat_c)
  );

  // Handshake and filter decisions
  assign in_ready  = !rst && !flush && (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign accept    = in_valid && in_ready;
  assign store     = accept && ((in_cat_c & cat_mask) != '0);
  assign drop      = accept && !store;
  assign pop       = out_valid && out_ready && !flush;
  assign in_entry  = '{instr: in_instr, cat: in_cat_c};

  assign out_instr = head.instr;
  assign out_cat   = head.cat;

  // Next pointers/occupancy; head register tracks the entry at the next read
  // pointer, taking the incoming word when it lands in that slot this edge.
  always_comb begin
    rd_ptr_nx = rd_ptr;
    wr_ptr_nx = wr_ptr;
    count_nx  = count;
    head_nx   = head;
    if (flush) begin
      rd_ptr_nx = '0;
      wr_ptr_nx = '0;
      count_nx  = '0;
    end else begin
      if (pop)   rd_ptr_nx = rd_ptr + PTR_W'(1);
      if (store) wr_ptr_nx = wr_ptr + PTR_W'(1);
      case ({store, pop})
        2'b10:   count_nx = count + CNT_W'(1);
        2'b01:   count_nx = count - CNT_W'(1);
        default: count_nx = count;
      endcase
      if (count_nx != '0) begin
        head_nx = (store && (wr_ptr == rd_ptr_nx)) ? in_entry : mem[rd_ptr_nx];
      end
    end
  end

  // Control state
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      head     <= '0;
      drop_cnt <= '0;
    end else begin
      rd_ptr <= rd_ptr_nx;
      wr_ptr <= wr_ptr_nx;
      count  <= count_nx;
      head   <= head_nx;
      if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
    end
  end

  // Entry storage, no reset needed: reads are qualified by count
  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr] <= in_entry;
  end

`ifdef INSTR_ISSUE_STATS_EN
  // Per-category counts of stored words; survive flush
  always_ff @(posedge clk) begin
    if (rst) begin
      load_cnt  <= '0;
      store_cnt <= '0;
      arith_cnt <= '0;
    end else if (store) begin
      case (in_cat_c)
        CAT_LOAD:  load_cnt  <= load_cnt + 32'(1);
        CAT_STORE: store_cnt <= store_cnt + 32'(1);
        CAT_ARITH: arith_cnt <= arith_cnt + 32'(1);
        default:   ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_instr_issue_buffer.sv
// Self-checking bench for instr_issue_buffer: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_instr_issue_buffer;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [2:0]  cat_mask;
  logic [31:0] in_instr;
  logic        in_ready, out_valid;
  logic [31:0] out_instr;
  logic [2:0]  out_cat;
  logic [3:0]  count;
  logic [15:0] drop_cnt;
`ifdef INSTR_ISSUE_STATS_EN
  logic [31:0] load_cnt, store_cnt, arith_cnt;
`endif

  instr_issue_buffer #(.DEPTH(DEPTH), .DROP_CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .cat_mask(cat_mask),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_cat(out_cat),
    .count(count), .drop_cnt(drop_cnt)
`ifdef INSTR_ISSUE_STATS_EN
    , .load_cnt(load_cnt), .store_cnt(store_cnt), .arith_cnt(arith_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model state
  typedef struct {
    logic [31:0] instr;
    logic [2:0]  cat;
  } ment_t;

  ment_t       q[$];
  logic [31:0] m_head_instr;
  logic [2:0]  m_head_cat;
  logic [15:0] m_drop;
  int unsigned m_load, m_store, m_arith;

  int unsigned vectors;
  int unsigned miscompares;

  localparam logic [31:0] LW  = 32'h00002083;
  localparam logic [31:0] SW  = 32'h00112023;
  localparam logic [31:0] ADD = 32'h00208033;
  localparam logic [31:0] JAL = 32'h0000006F;

  function automatic logic [2:0] classify(input logic [31:0] w);
    logic [6:0] opc;
    opc = w[6:0];
    if (opc == 7'b0000011) return 3'b001;
    if (opc == 7'b0100011) return 3'b010;
    if (opc == 7'b0110011 || opc == 7'b0010011) return 3'b100;
    return 3'b000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_head_instr = '0;
    m_head_cat   = '0;
    m_drop       = '0;
    m_load = 0; m_store = 0; m_arith = 0;
  endtask

  // Apply one clock edge's worth of behaviour using the inputs present at the edge
  task automatic model_edge();
    bit          rdy;
    logic [2:0]  c;
    ment_t       e;
    if (rst) begin
      model_reset();
      return;
    end
    rdy = !flush && (q.size() != DEPTH);
    if (flush) begin
      q.delete();
    end else begin
      if (out_ready && q.size() > 0) void'(q.pop_front());
      if (in_valid && rdy) begin
        c = classify(in_instr);
        if ((c & cat_mask) != 3'b000) begin
          e.instr = in_instr;
          e.cat   = c;
          q.push_back(e);
          if (c == 3'b001) m_load++;
          if (c == 3'b010) m_store++;
          if (c == 3'b100) m_arith++;
        end else if (m_drop != 16'hFFFF) begin
          m_drop++;
        end
      end
    end
    if (q.size() > 0) begin
      m_head_instr = q[0].instr;
      m_head_cat   = q[0].cat;
    end
  endtask

  task automatic check_outputs();
    chk("in_ready", 32'(in_ready), 32'(!rst && !flush && (q.size() != DEPTH)));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("out_instr", out_instr, m_head_instr);
    chk("out_cat", 32'(out_cat), 32'(m_head_cat));
    chk("count", 32'(count), 32'(q.size()));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
`ifdef INSTR_ISSUE_STATS_EN
    chk("load_cnt", load_cnt, m_load);
    chk("store_cnt", store_cnt, m_store);
    chk("arith_cnt", arith_cnt, m_arith);
`endif
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] w);
    in_valid = v;
    in_instr = w;
    cycle();
  endtask

  logic [6:0] opcs [6];

  initial begin
    logic [31:0] r;
    int          guard;
    opcs = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011};
    vectors = 0;
    miscompares = 0;
    rst = 1'b1; flush = 1'b0; cat_mask = 3'b111;
    in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
    model_reset();

    // Reset, then confirm reset state
    @(posedge clk); #1;
    cycle();
    rst = 1'b0;
    cycle();

    // All categories enabled, consumer always ready
    cat_mask = 3'b111; out_ready = 1'b1;
    drive(1'b1, LW);
    drive(1'b1, SW);
    drive(1'b1, ADD);
    drive(1'b0, '0);
    drive(1'b0, '0);

    // Only LOAD enabled: SW and ADD dropped
    cat_mask = 3'b001;
    drive(1'b1, SW);
    drive(1'b1, ADD);
    drive(1'b1, LW);
    drive(1'b0, '0);
    chk("drop_after_mask", 32'(drop_cnt), 32'd2);
    drive(1'b0, '0);

    // Fill to full with consumer stalled, then a single pop
    cat_mask = 3'b111; out_ready = 1'b0;
    for (int i = 0; i < 9; i++) drive(1'b1, LW | (32'(i) << 20));
    chk("full_count", 32'(count), 32'd8);
    chk("full_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    drive(1'b1, LW | (32'd8 << 20));
    out_ready = 1'b0;
    drive(1'b1, LW | (32'd9 << 20));
    chk("refill_count", 32'(count), 32'd8);

    // Flush while full with valid input
    flush = 1'b1;
    drive(1'b1, SW);
    flush = 1'b0;
    drive(1'b0, '0);
    chk("flush_count", 32'(count), 32'd0);

    // Unsupported opcode is dropped even with every category enabled
    drive(1'b1, JAL);
    drive(1'b0, '0);

    // Reset with five entries buffered
    for (int i = 0; i < 5; i++) drive(1'b1, (i % 2 == 0) ? ADD : SW);
    rst = 1'b1;
    drive(1'b1, LW);
    rst = 1'b0;
    drive(1'b0, '0);
    chk("rst_out_instr", out_instr, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      rst       = ($urandom_range(0, 79) == 0);
      flush     = ($urandom_range(0, 24) == 0);
      cat_mask  = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 2) != 0);
      r         = $urandom();
      r[6:0]    = opcs[$urandom_range(0, 5)];
      drive($urandom_range(0, 3) != 0, r);
    end
    rst = 1'b0; flush = 1'b0;

    // Drive drop_cnt to saturation and beyond
    cat_mask = 3'b111; out_ready = 1'b1;
    guard = 0;
    while (m_drop != 16'hFFFF && guard < 70000) begin
      drive(1'b1, JAL);
      guard++;
    end
    chk("sat_reached", 32'(m_drop), 32'h0000FFFF);
    for (int i = 0; i < 3; i++) drive(1'b1, JAL);
    drive(1'b0, '0);
    chk("drop_sat", 32'(drop_cnt), 32'h0000FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
